// File: rtl/bcd_serial_add_ctrl_if.sv
// Host-side bundle for the serial BCD adder sequencer.
//
// Handshake: the host raises start with a, b and cin valid; the block accepts
// them on the first rising edge that sees start=1 while idle (busy=0, done=0).
// busy then stays high while digits are processed, and done pulses for one
// cycle when sum/cout/err are valid. start is ignored whenever busy or done is
// high. Results hold until the next accepted start.
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                start;
    logic [4*DIGITS-1:0] a;
    logic [4*DIGITS-1:0] b;
    logic                cin;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] sum;
    logic                cout;
    logic                err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder sequencer. One single-digit add/correct stage
// is time-shared across the digits, least-significant first, with the digit
// carry held in a register between cycles.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    bcd_serial_add_ctrl_if.slave         bus,
    output logic [1:0]                   state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] a_q, a_d;
    logic [4*DIGITS-1:0] b_q, b_d;
    logic                carry_q, carry_d;
    logic [4*DIGITS-1:0] sum_q, sum_d;
    logic                cout_q, cout_d;
    logic                err_q, err_d;

    // Single-digit datapath signals for the digit selected by idx_q
    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [4:0] t_raw;
    logic [4:0] t_adj;
    logic [3:0] dig_out;
    logic       dig_carry;
    logic       dig_bad;
    logic       last_dig;

    // Select the current operand digits and apply the BCD decimal correction
    always_comb begin
        a_dig = 4'd0;
        b_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        t_raw     = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};
        t_adj     = t_raw + 5'd6;
        dig_carry = (t_raw > 5'd9);
        dig_out   = dig_carry ? t_adj[3:0] : t_raw[3:0];
        dig_bad   = (a_dig > 4'd9) || (b_dig > 4'd9);
        last_dig  = (idx_q == IDXW'(DIGITS - 1));
    end

    // Next-state and register-update logic for the sequencer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[4*i +: 4] = dig_out;
                    end
                end
                carry_d = dig_carry;
                if (dig_bad) begin
                    err_d = 1'b1;
                end
                if (last_dig) begin
                    // Index stays put on the last digit so it never wraps
                    cout_d  = dig_carry;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    // Status outputs decode directly from registered state
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.err   = err_q;
    assign state_dbg = state_q;

endmodule
